// File: rtl/spike_row_arbiter_if.sv
// Handshake and data bundle between a spike source/sink and spike_row_arbiter.
// master drives stimulus and recurrent inputs; slave is the arbiter itself.
interface spike_row_arbiter_if #(
    parameter int NUM_SYNAPSE_ROWS = 2,
    parameter int NUM_COLS         = 2,
    parameter int ADDR_WIDTH       = 6,
    parameter int ROW_W            = (NUM_SYNAPSE_ROWS > 1) ? $clog2(NUM_SYNAPSE_ROWS) : 1
);
    logic                           ext_valid;
    logic                           ext_ready;
    logic [ROW_W-1:0]               ext_row;
    logic [ADDR_WIDTH-1:0]          ext_addr;
    logic [NUM_COLS-1:0]            nrn_spike;
    logic [NUM_COLS*ROW_W-1:0]      route_row;
    logic [NUM_COLS*ADDR_WIDTH-1:0] route_addr;
    logic [NUM_SYNAPSE_ROWS-1:0]    out_row_strobe;
    logic [ADDR_WIDTH-1:0]          out_addr;
    logic [15:0]                    drop_count;
    logic [NUM_COLS-1:0]            pending;

    modport master (
        output ext_valid, ext_row, ext_addr, nrn_spike, route_row, route_addr,
        input  ext_ready, out_row_strobe, out_addr, drop_count, pending
    );

    modport slave (
        input  ext_valid, ext_row, ext_addr, nrn_spike, route_row, route_addr,
        output ext_ready, out_row_strobe, out_addr, drop_count, pending
    );
endinterface

// File: rtl/spike_row_arbiter.sv
// Merges external stimulus spikes and recurrent neuron spikes onto a single
// one-hot synapse-row strobe per cycle, alternating priority on conflicts.
module spike_row_arbiter #(
    parameter int NUM_SYNAPSE_ROWS = 2,
    parameter int NUM_COLS         = 2,
    parameter int ADDR_WIDTH       = 6,
    parameter int ROW_W            = (NUM_SYNAPSE_ROWS > 1) ? $clog2(NUM_SYNAPSE_ROWS) : 1
) (
    input  logic               clk,
    input  logic               reset,
    spike_row_arbiter_if.slave bus
);
    localparam int COL_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;

    typedef enum logic {
        PRIO_EXT = 1'b0,
        PRIO_REC = 1'b1
    } prio_e;

    prio_e                       r_state;
    prio_e                       w_state_nxt;
    logic [NUM_COLS-1:0]         r_pending;
    logic [NUM_COLS-1:0]         w_pending_nxt;
    logic [NUM_COLS-1:0]         w_lost;
    logic [NUM_SYNAPSE_ROWS-1:0] r_strobe;
    logic [NUM_SYNAPSE_ROWS-1:0] w_strobe_nxt;
    logic [ADDR_WIDTH-1:0]       r_addr;
    logic [ADDR_WIDTH-1:0]       w_addr_nxt;
    logic [15:0]                 r_drop;
    logic [15:0]                 w_drop_nxt;
    logic [16:0]                 w_drop_sum;

    logic                        w_ext_req;
    logic                        w_rec_req;
    logic                        w_grant_ext;
    logic                        w_grant_rec;
    logic                        w_grant_any;
    logic                        w_row_bad;
    logic                        w_clear;
    logic [COL_W-1:0]            w_rec_col;
    logic [ROW_W-1:0]            w_rec_row;
    logic [ROW_W-1:0]            w_gnt_row;
    logic [ADDR_WIDTH-1:0]       w_rec_addr;
    logic [ADDR_WIDTH-1:0]       w_gnt_addr;

    // External requests are masked during reset so ext_ready stays low.
    assign w_ext_req   = bus.ext_valid & reset;
    assign w_rec_req   = |r_pending;
    assign w_grant_any = w_grant_ext | w_grant_rec;

    // NOTE: every signal gets a default before any conditional assignment, so
    // no path through an always_comb can leave a value unassigned (no latch).
    // The scan runs high-to-low so the lowest pending column is the last write.
    always_comb begin
        w_rec_col  = '0;
        w_rec_row  = '0;
        w_rec_addr = '0;
        for (int c = NUM_COLS - 1; c >= 0; c--) begin
            if (r_pending[c]) begin
                w_rec_col  = COL_W'(c);
                w_rec_row  = bus.route_row[c*ROW_W +: ROW_W];
                w_rec_addr = bus.route_addr[c*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    // Priority FSM: the state names the winner of the next conflict.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_ext = 1'b0;
        w_grant_rec = 1'b0;
        if (w_ext_req && w_rec_req) begin
            if (r_state == PRIO_EXT) begin
                w_grant_ext = 1'b1;
                w_state_nxt = PRIO_REC;
            end else begin
                w_grant_rec = 1'b1;
                w_state_nxt = PRIO_EXT;
            end
        end else if (w_ext_req) begin
            w_grant_ext = 1'b1;
        end else if (w_rec_req) begin
            w_grant_rec = 1'b1;
        end
    end

    always_comb begin
        w_gnt_row    = w_grant_ext ? bus.ext_row  : w_rec_row;
        w_gnt_addr   = w_grant_ext ? bus.ext_addr : w_rec_addr;
        w_strobe_nxt = '0;
        for (int r = 0; r < NUM_SYNAPSE_ROWS; r++) begin
            w_strobe_nxt[r] = w_grant_any && (w_gnt_row == ROW_W'(r));
        end
        // A granted row with no matching strobe bit is out of range.
        w_row_bad  = w_grant_any && (w_strobe_nxt == '0);
        w_addr_nxt = w_grant_any ? w_gnt_addr : r_addr;
    end

    // A spike landing in the grant cycle re-arms pending; one landing on a
    // pending, ungranted column is lost.
    always_comb begin
        w_pending_nxt = r_pending;
        w_lost        = '0;
        w_clear       = 1'b0;
        w_drop_sum    = 17'(r_drop) + 17'(w_row_bad);
        for (int c = 0; c < NUM_COLS; c++) begin
            w_clear          = w_grant_rec && (w_rec_col == COL_W'(c));
            w_lost[c]        = bus.nrn_spike[c] & r_pending[c] & ~w_clear;
            w_pending_nxt[c] = (r_pending[c] & ~w_clear) | bus.nrn_spike[c];
            w_drop_sum       = w_drop_sum + 17'(w_lost[c]);
        end
        w_drop_nxt = w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
    end

    // NOTE: registers use non-blocking assignments so each one samples the
    // pre-edge value of everything it reads, independent of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= PRIO_EXT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pending <= '0;
            r_strobe  <= '0;
            r_addr    <= '0;
            r_drop    <= '0;
        end else begin
            r_pending <= w_pending_nxt;
            r_strobe  <= w_strobe_nxt;
            r_addr    <= w_addr_nxt;
            r_drop    <= w_drop_nxt;
        end
    end

    assign bus.ext_ready      = w_grant_ext;
    assign bus.out_row_strobe = r_strobe;
    assign bus.out_addr       = r_addr;
    assign bus.drop_count     = r_drop;
    assign bus.pending        = r_pending;
endmodule

// File: tb/tb_spike_row_arbiter.sv
// Self-checking bench for spike_row_arbiter: directed scenarios plus random
// traffic compared against a cycle-level behavioural model.
module tb_spike_row_arbiter;
    localparam int NSR = 3;
    localparam int NC  = 2;
    localparam int AW  = 6;
    localparam int RW  = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    spike_row_arbiter_if #(.NUM_SYNAPSE_ROWS(NSR), .NUM_COLS(NC), .ADDR_WIDTH(AW), .ROW_W(RW)) bus ();

    spike_row_arbiter #(.NUM_SYNAPSE_ROWS(NSR), .NUM_COLS(NC), .ADDR_WIDTH(AW), .ROW_W(RW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model state
    bit             m_pend [NC];
    bit             m_prio_ext = 1'b1;
    int             m_drop = 0;
    logic [NSR-1:0] m_strobe = '0;
    logic [AW-1:0]  m_addr = '0;
    logic           m_ready = 1'b0;
    logic           obs_ready = 1'b0;
    int             rt_row  [NC];
    int             rt_addr [NC];

    function automatic logic [NC-1:0] pend_vec();
        logic [NC-1:0] v;
        for (int c = 0; c < NC; c++) v[c] = m_pend[c];
        return v;
    endfunction

    task automatic apply_routes();
        for (int c = 0; c < NC; c++) begin
            bus.route_row[c*RW +: RW]  = RW'(rt_row[c]);
            bus.route_addr[c*AW +: AW] = AW'(rt_addr[c]);
        end
    endtask

    // One clock: samples ext_ready before the edge, advances the model, and
    // returns at the following falling edge where outputs are compared.
    task automatic cycle();
        int  rec_col;
        int  row;
        int  addr;
        int  lost;
        bit  g_ext;
        bit  g_rec;
        bit  nxt [NC];
        #1;
        obs_ready = bus.ext_ready;
        rec_col = -1;
        for (int c = 0; c < NC; c++) if (m_pend[c] && rec_col < 0) rec_col = c;
        if (reset !== 1'b1) begin
            m_ready = 1'b0;
            @(posedge clk);
            for (int c = 0; c < NC; c++) m_pend[c] = 1'b0;
            m_prio_ext = 1'b1;
            m_drop     = 0;
            m_strobe   = '0;
            m_addr     = '0;
        end else begin
            g_ext = bus.ext_valid && (rec_col < 0 || m_prio_ext);
            g_rec = (rec_col >= 0) && !g_ext;
            if (bus.ext_valid && rec_col >= 0) m_prio_ext = !m_prio_ext;
            m_ready = g_ext;
            lost = 0;
            for (int c = 0; c < NC; c++) begin
                nxt[c] = m_pend[c] && !(g_rec && c == rec_col);
                if (bus.nrn_spike[c]) begin
                    if (nxt[c]) lost++;
                    nxt[c] = 1'b1;
                end
            end
            row  = -1;
            addr = 0;
            if (g_ext) begin
                row  = int'(bus.ext_row);
                addr = int'(bus.ext_addr);
            end else if (g_rec) begin
                row  = rt_row[rec_col];
                addr = rt_addr[rec_col];
            end
            @(posedge clk);
            m_strobe = '0;
            if (row >= 0) begin
                m_addr = AW'(addr);
                if (row < NSR) m_strobe = NSR'(1 << row);
                else lost++;
            end
            m_drop = (m_drop + lost > 65535) ? 65535 : m_drop + lost;
            for (int c = 0; c < NC; c++) m_pend[c] = nxt[c];
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.ext_valid = 1'b1; bus.ext_row = 2'd1; bus.ext_addr = 6'd9;
        bus.nrn_spike = 2'b11;
        cycle();
        cycle();
        n_vec++; if (obs_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got %b want 0", obs_ready); end
        n_vec++; if (bus.out_row_strobe !== 3'b000) begin n_err++; $display("FAIL reset_strobe got %b want 000", bus.out_row_strobe); end
        n_vec++; if (bus.out_addr !== 6'd0) begin n_err++; $display("FAIL reset_addr got %0d want 0", bus.out_addr); end
        n_vec++; if (bus.drop_count !== 16'd0) begin n_err++; $display("FAIL reset_drop got %0d want 0", bus.drop_count); end
        n_vec++; if (bus.pending !== 2'b00) begin n_err++; $display("FAIL reset_pending got %b want 00", bus.pending); end
        reset = 1'b1; bus.ext_valid = 1'b0; bus.nrn_spike = 2'b00;
        cycle();
        n_vec++; if (bus.out_row_strobe !== 3'b000) begin n_err++; $display("FAIL reset_idle_strobe got %b want 000", bus.out_row_strobe); end
    endtask

    task automatic test_ext_single();
        bus.ext_valid = 1'b1; bus.ext_row = 2'd1; bus.ext_addr = 6'd5;
        cycle();
        n_vec++; if (obs_ready !== 1'b1) begin n_err++; $display("FAIL ext_ready got %b want 1", obs_ready); end
        n_vec++; if (bus.out_row_strobe !== 3'b010) begin n_err++; $display("FAIL ext_strobe got %b want 010", bus.out_row_strobe); end
        n_vec++; if (bus.out_addr !== 6'd5) begin n_err++; $display("FAIL ext_addr got %0d want 5", bus.out_addr); end
        bus.ext_valid = 1'b0;
        cycle();
        n_vec++; if (bus.out_row_strobe !== 3'b000) begin n_err++; $display("FAIL ext_idle_strobe got %b want 000", bus.out_row_strobe); end
        n_vec++; if (bus.out_addr !== 6'd5) begin n_err++; $display("FAIL ext_addr_hold got %0d want 5", bus.out_addr); end
    endtask

    task automatic test_recurrent();
        logic [2:0] exp_strobe [2] = '{3'b001, 3'b010};
        logic [5:0] exp_addr   [2] = '{6'd2, 6'd3};
        logic [1:0] exp_pend   [2] = '{2'b10, 2'b00};
        bus.nrn_spike = 2'b11;
        cycle();
        bus.nrn_spike = 2'b00;
        n_vec++; if (bus.pending !== 2'b11) begin n_err++; $display("FAIL rec_pending got %b want 11", bus.pending); end
        n_vec++; if (bus.out_row_strobe !== 3'b000) begin n_err++; $display("FAIL rec_first_strobe got %b want 000", bus.out_row_strobe); end
        for (int i = 0; i < 2; i++) begin
            cycle();
            n_vec++; if (bus.out_row_strobe !== exp_strobe[i]) begin n_err++; $display("FAIL rec_strobe[%0d] got %b want %b", i, bus.out_row_strobe, exp_strobe[i]); end
            n_vec++; if (bus.out_addr !== exp_addr[i]) begin n_err++; $display("FAIL rec_addr[%0d] got %0d want %0d", i, bus.out_addr, exp_addr[i]); end
            n_vec++; if (bus.pending !== exp_pend[i]) begin n_err++; $display("FAIL rec_pend[%0d] got %b want %b", i, bus.pending, exp_pend[i]); end
        end
    endtask

    task automatic test_alternate();
        logic       exp_rdy    [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [2:0] exp_strobe [4] = '{3'b100, 3'b001, 3'b100, 3'b010};
        logic [5:0] exp_addr   [4] = '{6'd7, 6'd2, 6'd7, 6'd3};
        bus.nrn_spike = 2'b11;
        cycle();
        bus.nrn_spike = 2'b00;
        bus.ext_valid = 1'b1; bus.ext_row = 2'd2; bus.ext_addr = 6'd7;
        for (int i = 0; i < 4; i++) begin
            cycle();
            n_vec++; if (obs_ready !== exp_rdy[i]) begin n_err++; $display("FAIL alt_ready[%0d] got %b want %b", i, obs_ready, exp_rdy[i]); end
            n_vec++; if (bus.out_row_strobe !== exp_strobe[i]) begin n_err++; $display("FAIL alt_strobe[%0d] got %b want %b", i, bus.out_row_strobe, exp_strobe[i]); end
            n_vec++; if (bus.out_addr !== exp_addr[i]) begin n_err++; $display("FAIL alt_addr[%0d] got %0d want %0d", i, bus.out_addr, exp_addr[i]); end
        end
        bus.ext_valid = 1'b0;
        cycle();
    endtask

    task automatic test_collision();
        bus.nrn_spike = 2'b01;
        cycle();
        n_vec++; if (bus.pending !== 2'b01) begin n_err++; $display("FAIL col_arm_pending got %b want 01", bus.pending); end
        // External wins the conflict; the second pulse is lost.
        bus.ext_valid = 1'b1; bus.ext_row = 2'd0; bus.ext_addr = 6'd11;
        cycle();
        n_vec++; if (obs_ready !== 1'b1) begin n_err++; $display("FAIL col_ext_ready got %b want 1", obs_ready); end
        n_vec++; if (bus.drop_count !== 16'd1) begin n_err++; $display("FAIL col_drop got %0d want 1", bus.drop_count); end
        n_vec++; if (bus.pending !== 2'b01) begin n_err++; $display("FAIL col_pending got %b want 01", bus.pending); end
        // Recurrent column 0 granted while pulsed again: no loss.
        cycle();
        n_vec++; if (obs_ready !== 1'b0) begin n_err++; $display("FAIL col_grant_ready got %b want 0", obs_ready); end
        n_vec++; if (bus.drop_count !== 16'd1) begin n_err++; $display("FAIL col_grant_drop got %0d want 1", bus.drop_count); end
        n_vec++; if (bus.pending !== 2'b01) begin n_err++; $display("FAIL col_grant_pending got %b want 01", bus.pending); end
        n_vec++; if (bus.out_addr !== 6'd2) begin n_err++; $display("FAIL col_grant_addr got %0d want 2", bus.out_addr); end
        bus.nrn_spike = 2'b00;
        cycle();
        n_vec++; if (bus.out_addr !== 6'd11) begin n_err++; $display("FAIL col_ext2_addr got %0d want 11", bus.out_addr); end
        bus.ext_valid = 1'b0;
        cycle();
        n_vec++; if (bus.pending !== 2'b00) begin n_err++; $display("FAIL col_drain_pending got %b want 00", bus.pending); end
        n_vec++; if (bus.out_row_strobe !== 3'b001) begin n_err++; $display("FAIL col_drain_strobe got %b want 001", bus.out_row_strobe); end
    endtask

    task automatic test_out_of_range();
        bus.ext_valid = 1'b1; bus.ext_row = 2'd3; bus.ext_addr = 6'd13;
        cycle();
        bus.ext_valid = 1'b0;
        n_vec++; if (obs_ready !== 1'b1) begin n_err++; $display("FAIL oor_ext_ready got %b want 1", obs_ready); end
        n_vec++; if (bus.out_row_strobe !== 3'b000) begin n_err++; $display("FAIL oor_ext_strobe got %b want 000", bus.out_row_strobe); end
        n_vec++; if (bus.drop_count !== 16'd2) begin n_err++; $display("FAIL oor_ext_drop got %0d want 2", bus.drop_count); end
        rt_row[1] = 3;
        apply_routes();
        bus.nrn_spike = 2'b10;
        cycle();
        bus.nrn_spike = 2'b00;
        cycle();
        n_vec++; if (bus.out_row_strobe !== 3'b000) begin n_err++; $display("FAIL oor_rec_strobe got %b want 000", bus.out_row_strobe); end
        n_vec++; if (bus.drop_count !== 16'd3) begin n_err++; $display("FAIL oor_rec_drop got %0d want 3", bus.drop_count); end
        n_vec++; if (bus.pending !== 2'b00) begin n_err++; $display("FAIL oor_rec_pending got %b want 00", bus.pending); end
        rt_row[1] = 1;
        apply_routes();
    endtask

    task automatic test_random();
        for (int c = 0; c < NC; c++) begin
            rt_row[c]  = $urandom_range(0, 3);
            rt_addr[c] = $urandom_range(0, 63);
        end
        apply_routes();
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 63) != 0);
            if (!(bus.ext_valid && !obs_ready)) begin
                bus.ext_valid = $urandom_range(0, 1);
                bus.ext_row   = RW'($urandom_range(0, 3));
                bus.ext_addr  = AW'($urandom_range(0, 63));
            end
            bus.nrn_spike = NC'($urandom_range(0, 3));
            cycle();
            n_vec++; if (obs_ready !== m_ready) begin n_err++; $display("FAIL rnd_ready[%0d] got %b want %b", i, obs_ready, m_ready); end
            n_vec++; if (bus.out_row_strobe !== m_strobe) begin n_err++; $display("FAIL rnd_strobe[%0d] got %b want %b", i, bus.out_row_strobe, m_strobe); end
            n_vec++; if (bus.out_addr !== m_addr) begin n_err++; $display("FAIL rnd_addr[%0d] got %0d want %0d", i, bus.out_addr, m_addr); end
            n_vec++; if (bus.drop_count !== 16'(m_drop)) begin n_err++; $display("FAIL rnd_drop[%0d] got %0d want %0d", i, bus.drop_count, m_drop); end
            n_vec++; if (bus.pending !== pend_vec()) begin n_err++; $display("FAIL rnd_pending[%0d] got %b want %b", i, bus.pending, pend_vec()); end
        end
        reset = 1'b1; bus.ext_valid = 1'b0; bus.nrn_spike = 2'b00;
        rt_row  = '{0, 1};
        rt_addr = '{2, 3};
        apply_routes();
        cycle(); cycle(); cycle();
    endtask

    task automatic test_saturation();
        int extra = 0;
        bus.ext_valid = 1'b1; bus.ext_row = 2'd3; bus.ext_addr = 6'd1;
        bus.nrn_spike = 2'b11;
        for (int i = 0; i < 40000 && extra < 8; i++) begin
            cycle();
            if (m_drop == 65535) extra++;
        end
        n_vec++; if (bus.drop_count !== 16'hFFFF) begin n_err++; $display("FAIL sat_drop got %h want ffff", bus.drop_count); end
        cycle();
        n_vec++; if (bus.drop_count !== 16'hFFFF) begin n_err++; $display("FAIL sat_hold got %h want ffff", bus.drop_count); end
        bus.ext_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        bus.nrn_spike = 2'b11;
        cycle();
        n_vec++; if (bus.pending !== 2'b11) begin n_err++; $display("FAIL rmid_pre_pending got %b want 11", bus.pending); end
        reset = 1'b0;
        bus.ext_valid = 1'b1; bus.ext_row = 2'd1; bus.ext_addr = 6'd4;
        cycle();
        n_vec++; if (obs_ready !== 1'b0) begin n_err++; $display("FAIL rmid_ready got %b want 0", obs_ready); end
        n_vec++; if (bus.out_row_strobe !== 3'b000) begin n_err++; $display("FAIL rmid_strobe got %b want 000", bus.out_row_strobe); end
        n_vec++; if (bus.out_addr !== 6'd0) begin n_err++; $display("FAIL rmid_addr got %0d want 0", bus.out_addr); end
        n_vec++; if (bus.drop_count !== 16'd0) begin n_err++; $display("FAIL rmid_drop got %0d want 0", bus.drop_count); end
        n_vec++; if (bus.pending !== 2'b00) begin n_err++; $display("FAIL rmid_pending got %b want 00", bus.pending); end
        reset = 1'b1; bus.ext_valid = 1'b0; bus.nrn_spike = 2'b00;
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_vec++; if (bus.out_row_strobe !== 3'b000) begin n_err++; $display("FAIL rmid_quiet_strobe[%0d] got %b want 000", i, bus.out_row_strobe); end
        end
        // Priority must have returned to external.
        bus.nrn_spike = 2'b01;
        cycle();
        bus.nrn_spike = 2'b00;
        bus.ext_valid = 1'b1;
        cycle();
        n_vec++; if (obs_ready !== 1'b1) begin n_err++; $display("FAIL rmid_prio_ready got %b want 1", obs_ready); end
        n_vec++; if (bus.out_row_strobe !== 3'b010) begin n_err++; $display("FAIL rmid_prio_strobe got %b want 010", bus.out_row_strobe); end
        bus.ext_valid = 1'b0;
        cycle();
        n_vec++; if (bus.out_row_strobe !== 3'b001) begin n_err++; $display("FAIL rmid_rec_strobe got %b want 001", bus.out_row_strobe); end
        n_vec++; if (bus.out_addr !== 6'd2) begin n_err++; $display("FAIL rmid_rec_addr got %0d want 2", bus.out_addr); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "simulation timeout");
    end

    initial begin
        rt_row  = '{0, 1};
        rt_addr = '{2, 3};
        bus.ext_valid = 1'b0;
        bus.ext_row   = '0;
        bus.ext_addr  = '0;
        bus.nrn_spike = '0;
        apply_routes();
        test_reset();
        test_ext_single();
        test_recurrent();
        test_alternate();
        test_collision();
        test_out_of_range();
        test_random();
        test_saturation();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
